// File: rtl/game_pkg.sv
// Shared types for the player-matrix writer.
//   cell_t     : cell encoding (EMPTY / CURSOR / PLACED; 3 is reserved)
//   wr_state_t : writer FSM states
//   matrix_t   : 5x5 grid of 2-bit cells, indexed [i][j]
//   scan_row / scan_col : raster index k -> (k/5, k%5)
package game_pkg;

    localparam int GRID_N = 5;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        CURSOR = 2'd1,
        PLACED = 2'd2
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        PLACE,
        SEEK,
        FULL
    } wr_state_t;

    typedef logic [0:GRID_N-1][0:GRID_N-1][1:0] matrix_t;

    function automatic matrix_t reset_matrix();
        matrix_t m;
        m       = '0;
        m[0][0] = CURSOR;
        return m;
    endfunction

    function automatic logic [2:0] scan_row(input logic [4:0] k);
        logic [4:0] q;
        q = k / 5'd5;
        return q[2:0];
    endfunction

    function automatic logic [2:0] scan_col(input logic [4:0] k);
        logic [4:0] r;
        r = k % 5'd5;
        return r[2:0];
    endfunction

endpackage

// File: rtl/matrix_cursor_writer_btn_edge.sv
// Button rising-edge detector.
//   clk, rst : clock and synchronous active-high reset
//   btn      : button level
//   rise     : high for one cycle after the registered level goes 0 -> 1
// A held button yields a single pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic q;
    logic q_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= 1'b0;
            q_d <= 1'b0;
        end else begin
            q   <= btn;
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;

endmodule

// File: rtl/matrix_cursor_writer.sv
// Writer side of the 5x5 player matrix: applies cursor moves and placements.
//   clk, rst                 : clock, synchronous active-high reset
//   direction                : 1 = +j / -i, 0 = -j / +i
//   move_h, move_v, select   : button levels (edge-triggered commands)
//   matrix_pc                : cell values (0 empty, 1 cursor, 2 placed)
//   cur_i, cur_j             : cursor position
//   placed_count             : number of placed cells (saturates at 25)
//   busy                     : high while seeking the next empty cell
//   done                     : one-cycle pulse after a placement's seek ends
//   full                     : sticky, no cursor remains
// Build option: define CURSOR_WRAP_EN to wrap out-of-range moves to the
// opposite edge instead of dropping them.
//
// state | meaning
// IDLE  | waiting for a button edge
// MOVE  | apply the latched move if the target cell is empty
// PLACE | mark cursor cell placed, bump count
// SEEK  | raster scan one cell per cycle for the next empty cell
// FULL  | no cursor left; absorbing until reset
module matrix_cursor_writer
    import game_pkg::*;
#(
    parameter int MAX_PLACE    = 25,
    parameter int SEEK_LAT_MAX = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       direction,
    input  logic       move_h,
    input  logic       move_v,
    input  logic       select,
    output matrix_t    matrix_pc,
    output logic [2:0] cur_i,
    output logic [2:0] cur_j,
    output logic [4:0] placed_count,
    output logic       busy,
    output logic       done,
    output logic       full
);

    localparam logic [4:0] LAST_PLACE = 5'(MAX_PLACE - 1);
    localparam logic [4:0] LAST_SCAN  = 5'(SEEK_LAT_MAX - 1);
    localparam logic [4:0] COUNT_SAT  = 5'd25;
    localparam logic [2:0] IDX_MAX    = 3'(GRID_N - 1);

    wr_state_t  state;
    logic       move_is_h;
    logic       move_dir;
    logic [4:0] scan_k;

    logic       h_rise;
    logic       v_rise;
    logic       sel_rise;

    logic [2:0] tgt_i;
    logic [2:0] tgt_j;
    logic       in_range;
    logic       tgt_ok;

    btn_edge u_edge_h   (.clk(clk), .rst(rst), .btn(move_h), .rise(h_rise));
    btn_edge u_edge_v   (.clk(clk), .rst(rst), .btn(move_v), .rise(v_rise));
    btn_edge u_edge_sel (.clk(clk), .rst(rst), .btn(select), .rise(sel_rise));

    // Bounds are checked before any add/subtract so an index never wraps
    // through 3-bit arithmetic.
    always_comb begin
        tgt_i    = cur_i;
        tgt_j    = cur_j;
        in_range = 1'b1;
        if (move_is_h) begin
            if (move_dir) begin
                if (cur_j < IDX_MAX) tgt_j = cur_j + 3'd1;
`ifdef CURSOR_WRAP_EN
                else tgt_j = 3'd0;
`else
                else in_range = 1'b0;
`endif
            end else begin
                if (cur_j != 3'd0) tgt_j = cur_j - 3'd1;
`ifdef CURSOR_WRAP_EN
                else tgt_j = IDX_MAX;
`else
                else in_range = 1'b0;
`endif
            end
        end else begin
            if (move_dir) begin
                if (cur_i != 3'd0) tgt_i = cur_i - 3'd1;
`ifdef CURSOR_WRAP_EN
                else tgt_i = IDX_MAX;
`else
                else in_range = 1'b0;
`endif
            end else begin
                if (cur_i < IDX_MAX) tgt_i = cur_i + 3'd1;
`ifdef CURSOR_WRAP_EN
                else tgt_i = 3'd0;
`else
                else in_range = 1'b0;
`endif
            end
        end
        tgt_ok = in_range && (matrix_pc[tgt_i][tgt_j] == EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            matrix_pc    <= reset_matrix();
            cur_i        <= 3'd0;
            cur_j        <= 3'd0;
            placed_count <= 5'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            full         <= 1'b0;
            state        <= IDLE;
            move_is_h    <= 1'b0;
            move_dir     <= 1'b0;
            scan_k       <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // select outranks move_h, which outranks move_v
                    if (sel_rise) begin
                        state <= PLACE;
                    end else if (h_rise) begin
                        move_is_h <= 1'b1;
                        move_dir  <= direction;
                        state     <= MOVE;
                    end else if (v_rise) begin
                        move_is_h <= 1'b0;
                        move_dir  <= direction;
                        state     <= MOVE;
                    end
                end
                MOVE: begin
                    if (tgt_ok) begin
                        matrix_pc[cur_i][cur_j] <= EMPTY;
                        matrix_pc[tgt_i][tgt_j] <= CURSOR;
                        cur_i <= tgt_i;
                        cur_j <= tgt_j;
                    end
                    state <= IDLE;
                end
                PLACE: begin
                    matrix_pc[cur_i][cur_j] <= PLACED;
                    if (placed_count != COUNT_SAT) placed_count <= placed_count + 5'd1;
                    if (placed_count == LAST_PLACE) begin
                        full  <= 1'b1;
                        state <= FULL;
                    end else begin
                        busy   <= 1'b1;
                        scan_k <= 5'd0;
                        state  <= SEEK;
                    end
                end
                SEEK: begin
                    if (matrix_pc[scan_row(scan_k)][scan_col(scan_k)] == EMPTY) begin
                        matrix_pc[scan_row(scan_k)][scan_col(scan_k)] <= CURSOR;
                        cur_i <= scan_row(scan_k);
                        cur_j <= scan_col(scan_k);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (scan_k == LAST_SCAN) begin
                        busy  <= 1'b0;
                        full  <= 1'b1;
                        state <= FULL;
                    end else begin
                        scan_k <= scan_k + 5'd1;
                    end
                end
                FULL: begin
                    state <= FULL;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_cursor_writer.sv
module tb_matrix_cursor_writer;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       direction = 1'b0;
    logic       move_h = 1'b0;
    logic       move_v = 1'b0;
    logic       select = 1'b0;
    logic       sel3 = 1'b0;
    logic       zero = 1'b0;

    matrix_t    matrix_pc;
    logic [2:0] cur_i;
    logic [2:0] cur_j;
    logic [4:0] placed_count;
    logic       busy;
    logic       done;
    logic       full;

    matrix_t    matrix3;
    logic [2:0] cur_i3;
    logic [2:0] cur_j3;
    logic [4:0] placed3;
    logic       busy3;
    logic       done3;
    logic       full3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    matrix_cursor_writer dut (
        .clk(clk), .rst(rst), .direction(direction), .move_h(move_h),
        .move_v(move_v), .select(select), .matrix_pc(matrix_pc),
        .cur_i(cur_i), .cur_j(cur_j), .placed_count(placed_count),
        .busy(busy), .done(done), .full(full)
    );

    matrix_cursor_writer #(.MAX_PLACE(3)) dut3 (
        .clk(clk), .rst(rst), .direction(zero), .move_h(zero),
        .move_v(zero), .select(sel3), .matrix_pc(matrix3),
        .cur_i(cur_i3), .cur_j(cur_j3), .placed_count(placed3),
        .busy(busy3), .done(done3), .full(full3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic h, input logic dir);
        direction = dir;
        if (h) move_h = 1'b1;
        else   move_v = 1'b1;
        step(1);
        move_h = 1'b0;
        move_v = 1'b0;
        step(3);
    endtask

    task automatic wait_place(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            step(1);
            if (done || full) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    function automatic int count_val(input matrix_t m, input logic [1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                if (m[i][j] == v) c++;
        return c;
    endfunction

    task automatic chk_reset(input string tag);
        matrix_t exp_m;
        exp_m       = '0;
        exp_m[0][0] = 2'd1;
        chk({tag, "_matrix"}, 64'(matrix_pc), 64'(exp_m));
        chk({tag, "_cur_i"}, 64'(cur_i), 64'd0);
        chk({tag, "_cur_j"}, 64'(cur_j), 64'd0);
        chk({tag, "_count"}, 64'(placed_count), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_full"}, 64'(full), 64'd0);
    endtask

    initial begin
        matrix_t saved;
        matrix_t all_placed;
        matrix_t exp3;

        // reset
        step(2);
        rst = 1'b0;
        chk_reset("reset");

        // +j move: two cycles from edge to matrix
        direction = 1'b1;
        move_h = 1'b1;
        step(1);
        move_h = 1'b0;
        step(1);
        chk("mv_h_latency", 64'(matrix_pc[0][1]), 64'd0);
        step(1);
        chk("mv_h_new", 64'(matrix_pc[0][1]), 64'd1);
        chk("mv_h_old", 64'(matrix_pc[0][0]), 64'd0);
        chk("mv_h_cur_j", 64'(cur_j), 64'd1);

        // held +i for 20 cycles: exactly one move (0,1)->(1,1)
        direction = 1'b0;
        move_v = 1'b1;
        step(20);
        move_v = 1'b0;
        step(3);
        chk("hold_cur_i", 64'(cur_i), 64'd1);
        chk("hold_cell11", 64'(matrix_pc[1][1]), 64'd1);
        chk("hold_cell21", 64'(matrix_pc[2][1]), 64'd0);

        // back to (0,0)
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        chk("home_pos", 64'({cur_i, cur_j}), 64'd0);

        // placement at (0,0) and seek to (0,1)
        select = 1'b1;
        step(1);
        select = 1'b0;
        step(1);
        step(1);
        chk("place_busy", 64'(busy), 64'd1);
        chk("place_cell00", 64'(matrix_pc[0][0]), 64'd2);
        step(1);
        chk("seek_done_early", 64'(done), 64'd0);
        step(1);
        chk("seek_done", 64'(done), 64'd1);
        chk("seek_busy_low", 64'(busy), 64'd0);
        chk("seek_cursor", 64'({cur_i, cur_j}), 64'({3'd0, 3'd1}));
        chk("seek_cell01", 64'(matrix_pc[0][1]), 64'd1);
        chk("seek_count", 64'(placed_count), 64'd1);
        step(1);
        chk("done_one_cycle", 64'(done), 64'd0);

        // -j into placed (0,0) is blocked
        saved = matrix_pc;
        press(1'b1, 1'b0);
        chk("blocked_matrix", 64'(matrix_pc), 64'(saved));
        chk("blocked_cur_j", 64'(cur_j), 64'd1);

        // walk to (4,4)
        for (int n = 0; n < 4; n++) press(1'b0, 1'b0);
        for (int n = 0; n < 3; n++) press(1'b1, 1'b1);
        chk("corner_pos", 64'({cur_i, cur_j}), 64'({3'd4, 3'd4}));

        // +j at the right edge
        press(1'b1, 1'b1);
`ifdef CURSOR_WRAP_EN
        chk("edge_wrap_cell40", 64'(matrix_pc[4][0]), 64'd1);
        chk("edge_wrap_cell44", 64'(matrix_pc[4][4]), 64'd0);
        chk("edge_wrap_cur_j", 64'(cur_j), 64'd0);
`else
        chk("edge_hold_cell44", 64'(matrix_pc[4][4]), 64'd1);
        chk("edge_hold_cell40", 64'(matrix_pc[4][0]), 64'd0);
        chk("edge_hold_cur_j", 64'(cur_j), 64'd4);
`endif

        // select and move_h in the same cycle: placement wins
        direction = 1'b1;
        select = 1'b1;
        move_h = 1'b1;
        step(1);
        select = 1'b0;
        move_h = 1'b0;
        step(8);
`ifdef CURSOR_WRAP_EN
        chk("simul_placed", 64'(matrix_pc[4][0]), 64'd2);
`else
        chk("simul_placed", 64'(matrix_pc[4][4]), 64'd2);
`endif
        chk("simul_count", 64'(placed_count), 64'd2);
        chk("simul_cursor", 64'({cur_i, cur_j}), 64'({3'd0, 3'd1}));
        chk("simul_cell02", 64'(matrix_pc[0][2]), 64'd0);

        // fill the remaining 23 cells
        for (int n = 3; n <= 25; n++) begin
            select = 1'b1;
            step(1);
            select = 1'b0;
            wait_place("fill_wait");
            step(2);
            if (n == 24) begin
                chk("fill24_full", 64'(full), 64'd0);
                chk("fill24_count", 64'(placed_count), 64'd24);
            end
        end
        all_placed = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                all_placed[i][j] = 2'd2;
        chk("full_flag", 64'(full), 64'd1);
        chk("full_count", 64'(placed_count), 64'd25);
        chk("full_no_cursor", 64'(count_val(matrix_pc, 2'd1)), 64'd0);
        chk("full_matrix", 64'(matrix_pc), 64'(all_placed));

        // buttons ignored once full
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        select = 1'b1;
        step(1);
        select = 1'b0;
        step(5);
        chk("full_ignore_matrix", 64'(matrix_pc), 64'(all_placed));
        chk("full_ignore_count", 64'(placed_count), 64'd25);
        chk("full_sticky", 64'(full), 64'd1);

        // one-cycle reset from FULL
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_reset("rerst");

        // MAX_PLACE = 3 instance: full right after PLACE, no seek
        for (int n = 0; n < 2; n++) begin
            sel3 = 1'b1;
            step(1);
            sel3 = 1'b0;
            step(8);
        end
        chk("mp3_count2", 64'(placed3), 64'd2);
        chk("mp3_full2", 64'(full3), 64'd0);
        sel3 = 1'b1;
        step(1);
        sel3 = 1'b0;
        step(2);
        chk("mp3_full", 64'(full3), 64'd1);
        chk("mp3_no_busy", 64'(busy3), 64'd0);
        chk("mp3_count3", 64'(placed3), 64'd3);
        exp3 = '0;
        exp3[0][0] = 2'd2;
        exp3[0][1] = 2'd2;
        exp3[0][2] = 2'd2;
        chk("mp3_matrix", 64'(matrix3), 64'(exp3));
        step(3);
        chk("mp3_no_done", 64'(done3), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
